pid_term: RTL and testbench
===========================

PID_TERM -- requirements
Module: pid_term

Interface
REQ-001 SHALL have parameter ERR_W, default 12, signed error input width.
REQ-002 SHALL have parameter SAT_W, default 10, saturated error width.
REQ-003 SHALL have parameter P_COEFF, default 4'h3, unsigned 4-bit proportional gain.
REQ-004 SHALL have parameter D_COEFF, default 4'h2, unsigned 4-bit derivative gain.
REQ-005 SHALL have parameter D_DEPTH, default 4, derivative history depth in samples (>=1).
REQ-006 SHALL have parameter I_W, default 16, signed integrator width.
REQ-007 SHALL have parameter I_SHIFT, default 4, integrator arithmetic right shift (< I_W).
REQ-008 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-009 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-010 SHALL have port err_vld  input  1  error sample valid this cycle.
REQ-011 SHALL have port error  input  ERR_W  signed error sample.
REQ-012 SHALL have port clr_integ  input  1  synchronous integrator clear.
REQ-013 SHALL have port P_term  output  SAT_W+4  signed proportional term.
REQ-014 SHALL have port I_term  output  I_W-I_SHIFT  signed integral term.
REQ-015 SHALL have port D_term  output  SAT_W+4  signed derivative term.
REQ-016 SHALL have port PID  output  SAT_W+6  signed sum of the three terms.
REQ-017 SHALL have port out_vld  output  1  one-cycle pulse marking new output values.

Function
REQ-018 SHALL saturate error to SAT_W signed: above 2^(SAT_W-1)-1 gives max, below -2^(SAT_W-1) gives min, otherwise pass-through.
REQ-019 SHALL register the saturated sample (stage 1) on every edge where err_vld=1; all other stage-1 state holds.
REQ-020 SHALL register P_term, I_term, D_term, PID (stage 2) one edge after stage 1 and pulse out_vld high for exactly that one cycle.
REQ-021 SHALL set latency to 2 edges: sample on edge N, outputs and out_vld visible after edge N+1.
REQ-022 SHALL sustain throughput of one sample per cycle with back-to-back err_vld.
REQ-023 SHALL hold every output between out_vld pulses.
REQ-024 SHALL compute P_term = err_sat * P_COEFF exactly, with no truncation.
REQ-025 SHALL add the sign-extended err_sat to the integrator on each stage-1 update, saturating at the I_W signed bounds (no wrap).
REQ-026 SHALL zero the integrator when clr_integ=1; clr_integ takes priority over a simultaneous sample, which is then excluded from the integrator but still produces P/D outputs.
REQ-027 SHALL compute I_term = integrator >>> I_SHIFT (arithmetic), using the post-update integrator value.
REQ-028 SHALL keep a D_DEPTH-entry history shift register of err_sat that advances only on valid samples; unfilled entries read 0.
REQ-029 SHALL compute diff = err_sat - history[D_DEPTH-1] (oldest), saturate it to SAT_W, then D_term = diff_sat * D_COEFF.
REQ-030 SHALL compute PID = P_term + I_term + D_term at full precision, then saturate to SAT_W+6 signed.

Reset
REQ-031 SHALL clear on rst: stage-1 register, integrator, history, all outputs and out_vld to 0.
REQ-032 SHALL give rst priority over err_vld and clr_integ; an in-flight sample is dropped and out_vld stays 0.
REQ-033 SHALL require err_vld to be sampled again after rst deasserts; no output is produced without a post-reset sample.

Verification (defaults)
REQ-034 SHALL verify P saturation: reset, error=12'h4CC one sample -> 2 edges later out_vld=1, P_term=1533 (511*3).
REQ-035 SHALL verify negative saturation: error=12'hAFF -> P_term=-1536; error=12'h0FF -> P_term=765.
REQ-036 SHALL verify the integrator: reset, 16 samples of 12'h1FF -> I_term=511; continue to 65 total samples -> integrator clamps at 32767, I_term=2047; clr_integ with a sample -> next I_term=0.
REQ-037 SHALL verify the derivative: reset, 5 samples of 100 -> D_term=200 for samples 1-4, D_term=0 for sample 5.
REQ-038 SHALL verify gapped input: samples separated by idle cycles -> out_vld pulses once per sample and outputs hold between pulses.
REQ-039 SHALL verify reset mid-operation: err_vld=1 at edge N, rst=1 at edge N+1 -> out_vld never pulses and all outputs read 0.

Source files
------------

// File: rtl/pid_term.sv
// Two-stage PID term generator: stage 1 saturates and registers each error sample
// and updates the integrator and history; stage 2 forms the P/I/D terms and their sum.
module pid_term #(
  parameter int         ERR_W   = 12,
  parameter int         SAT_W   = 10,
  parameter logic [3:0] P_COEFF = 4'h3,
  parameter logic [3:0] D_COEFF = 4'h2,
  parameter int         D_DEPTH = 4,
  parameter int         I_W     = 16,
  parameter int         I_SHIFT = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            err_vld,
  input  logic signed [ERR_W-1:0]         error,
  input  logic                            clr_integ,
  output logic signed [SAT_W+3:0]         P_term,
  output logic signed [I_W-I_SHIFT-1:0]   I_term,
  output logic signed [SAT_W+3:0]         D_term,
  output logic signed [SAT_W+5:0]         PID,
  output logic                            out_vld
);

  localparam int PW = SAT_W + 4;
  localparam int IW = I_W - I_SHIFT;
  localparam int OW = SAT_W + 6;
  localparam int AW = ((PW > IW) ? PW : IW) + 2;
  localparam int FW = (AW > OW) ? AW : OW;

  localparam logic signed [SAT_W-1:0] SMAX  = {1'b0, {(SAT_W-1){1'b1}}};
  localparam logic signed [SAT_W-1:0] SMIN  = {1'b1, {(SAT_W-1){1'b0}}};
  localparam logic signed [ERR_W-1:0] EMAX  = ERR_W'(SMAX);
  localparam logic signed [ERR_W-1:0] EMIN  = ERR_W'(SMIN);
  localparam logic signed [I_W-1:0]   ISMAX = {1'b0, {(I_W-1){1'b1}}};
  localparam logic signed [I_W-1:0]   ISMIN = {1'b1, {(I_W-1){1'b0}}};
  localparam logic signed [FW-1:0]    OMAX  = FW'({1'b0, {(OW-1){1'b1}}});
  localparam logic signed [FW-1:0]    OMIN  = FW'($signed({1'b1, {(OW-1){1'b0}}}));
  localparam logic signed [PW-1:0]    PC    = PW'(P_COEFF);
  localparam logic signed [PW-1:0]    DC    = PW'(D_COEFF);

  logic [1:0]                         vld_pipe_q;
  logic signed [SAT_W-1:0]            s1_q, dif_q;
  logic signed [I_W-1:0]              integ_q;
  logic [D_DEPTH-1:0][SAT_W-1:0]      hist_q;

  logic signed [SAT_W-1:0]            esat_d, dsat_d;
  logic signed [SAT_W:0]              diff;
  logic signed [I_W:0]                isum;
  logic signed [I_W-1:0]              integ_d;

  // Stage-1 combinational: input clamp, derivative against the oldest sample,
  // and the saturating integrator sum.
  always_comb begin
    esat_d = error[SAT_W-1:0];
    if (error > EMAX)      esat_d = SMAX;
    else if (error < EMIN) esat_d = SMIN;

    diff   = {esat_d[SAT_W-1], esat_d} - {hist_q[D_DEPTH-1][SAT_W-1], hist_q[D_DEPTH-1]};
    dsat_d = diff[SAT_W-1:0];
    if (diff[SAT_W] != diff[SAT_W-1]) dsat_d = diff[SAT_W] ? SMIN : SMAX;

    isum    = {integ_q[I_W-1], integ_q} + {{(I_W+1-SAT_W){esat_d[SAT_W-1]}}, esat_d};
    integ_d = isum[I_W-1:0];
    if (isum[I_W] != isum[I_W-1]) integ_d = isum[I_W] ? ISMIN : ISMAX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      dif_q      <= '0;
      integ_q    <= '0;
      hist_q     <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], err_vld};
      if (err_vld) begin
        s1_q      <= esat_d;
        dif_q     <= dsat_d;
        hist_q[0] <= esat_d;
        for (int k = 1; k < D_DEPTH; k++) hist_q[k] <= hist_q[k-1];
      end
      // A clear wins over a coincident sample, which then never reaches the integrator.
      if (clr_integ)    integ_q <= '0;
      else if (err_vld) integ_q <= integ_d;
    end
  end

  logic signed [PW-1:0] p_d, d_d;
  logic signed [IW-1:0] i_d;
  logic signed [FW-1:0] sum;
  logic signed [OW-1:0] pid_d;

  always_comb begin
    p_d   = PW'(s1_q) * PC;
    d_d   = PW'(dif_q) * DC;
    i_d   = IW'(integ_q >>> I_SHIFT);
    sum   = FW'(p_d) + FW'(i_d) + FW'(d_d);
    pid_d = sum[OW-1:0];
    if (sum > OMAX)      pid_d = OMAX[OW-1:0];
    else if (sum < OMIN) pid_d = OMIN[OW-1:0];
  end

  logic signed [PW-1:0] p_q, d_q;
  logic signed [IW-1:0] i_q;
  logic signed [OW-1:0] pid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q   <= '0;
      i_q   <= '0;
      d_q   <= '0;
      pid_q <= '0;
    end else if (vld_pipe_q[0]) begin
      p_q   <= p_d;
      i_q   <= i_d;
      d_q   <= d_d;
      pid_q <= pid_d;
    end
  end

  assign P_term  = p_q;
  assign I_term  = i_q;
  assign D_term  = d_q;
  assign PID     = pid_q;
  assign out_vld = vld_pipe_q[1];

endmodule

// File: tb/tb_pid_term.sv
// Randomized and directed bench for pid_term against a per-sample arithmetic reference model.
module tb_pid_term;
  localparam int ERR_W = 12, SAT_W = 10, PCO = 3, DCO = 2, D_DEPTH = 4, I_W = 16, I_SHIFT = 4;

  logic                         clk = 1'b0;
  logic                         rst, err_vld, clr_integ;
  logic signed [ERR_W-1:0]      error;
  logic signed [SAT_W+3:0]      P_term, D_term;
  logic signed [I_W-I_SHIFT-1:0] I_term;
  logic signed [SAT_W+5:0]      PID;
  logic                         out_vld;

  pid_term dut (
    .clk(clk), .rst(rst), .err_vld(err_vld), .error(error), .clr_integ(clr_integ),
    .P_term(P_term), .I_term(I_term), .D_term(D_term), .PID(PID), .out_vld(out_vld)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0, pulses = 0;
  // expected visible outputs, and the result waiting one edge to appear
  int m_vld = 0, m_p = 0, m_i = 0, m_d = 0, m_pid = 0;
  int pv = 0, pp = 0, pi = 0, pd = 0, ppid = 0;
  int integ = 0;
  int hist[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int x, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (x > hi) ? hi : (x < lo) ? lo : x;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_p = 0; m_i = 0; m_d = 0; m_pid = 0;
    pv = 0; integ = 0;
    hist.delete();
    for (int k = 0; k < D_DEPTH; k++) hist.push_back(0);
  endtask

  task automatic model_edge(input bit r, input bit v, input int e12, input bit c);
    int es;
    if (r) begin
      model_reset();
      return;
    end
    m_vld = pv;
    if (pv) begin m_p = pp; m_i = pi; m_d = pd; m_pid = ppid; end
    pv = v;
    if (c) integ = 0;
    if (v) begin
      es = sat(e12, SAT_W);
      if (!c) integ = sat(integ + es, I_W);
      pp   = es * PCO;
      pi   = integ >>> I_SHIFT;
      pd   = sat(es - hist[D_DEPTH-1], SAT_W) * DCO;
      ppid = sat(pp + pi + pd, SAT_W + 6);
      hist.push_front(es);
      void'(hist.pop_back());
    end
  endtask

  task automatic step(input bit r, input bit v, input int e, input bit c);
    logic [ERR_W-1:0] raw;
    raw = e[ERR_W-1:0];
    rst = r; err_vld = v; error = raw; clr_integ = c;
    @(posedge clk);
    model_edge(r, v, $signed(raw), c);
    @(negedge clk);
    chk("out_vld", int'(out_vld), m_vld);
    chk("P_term", int'(P_term), m_p);
    chk("I_term", int'(I_term), m_i);
    chk("D_term", int'(D_term), m_d);
    chk("PID", int'(PID), m_pid);
    if (out_vld) pulses++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; err_vld = 1'b0; error = '0; clr_integ = 1'b0;
    model_reset();
    @(negedge clk);
    step(1, 0, 0, 0);
    step(1, 1, 'h123, 1);
    chk("rst_vld", int'(out_vld), 0);
    chk("rst_pid", int'(PID), 0);

    // input clamp on P
    step(0, 1, 'h4CC, 0); idle();
    chk("p_sat_pos", int'(P_term), 1533);
    step(0, 1, 'hAFF, 0); idle();
    chk("p_sat_neg", int'(P_term), -1536);
    step(0, 1, 'h0FF, 0); idle();
    chk("p_pass", int'(P_term), 765);

    // integrator ramp, clamp, clear
    step(1, 0, 0, 0);
    for (int k = 0; k < 16; k++) step(0, 1, 'h1FF, 0);
    idle();
    chk("i_16", int'(I_term), 511);
    for (int k = 16; k < 65; k++) step(0, 1, 'h1FF, 0);
    idle();
    chk("i_clamp", int'(I_term), 2047);
    step(0, 1, 'h1FF, 1); idle();
    chk("i_clr", int'(I_term), 0);

    // derivative over a 4-deep history
    step(1, 0, 0, 0);
    for (int k = 0; k <= 5; k++) begin
      step(0, (k < 5), 100, 0);
      if (k > 0) chk("d_hist", int'(D_term), (k < 5) ? 200 : 0);
    end

    // gapped samples: one pulse per sample, hold in between
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step(0, 1, int'($urandom_range(0, 4095)), 0);
      for (int g = 0; g < 3; g++) idle();
    end
    chk("gap_pulses", pulses, 6);

    // reset lands on the edge after a sample
    step(1, 0, 0, 0);
    pulses = 0;
    step(0, 1, 50, 0);
    step(1, 0, 0, 0);
    for (int g = 0; g < 3; g++) idle();
    chk("rst_drop_pulses", pulses, 0);
    chk("rst_drop_p", int'(P_term), 0);
    chk("rst_drop_pid", int'(PID), 0);

    // random traffic
    for (int n = 0; n < 600; n++)
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 65),
           int'($urandom_range(0, 4095)), ($urandom_range(0, 99) < 5));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
